// File: rtl/uart_pkg.sv
// Shared definitions for the streaming UART transmitter: FSM states and
// parity_mode encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_RSVD = 2'b11;

  function automatic logic parity_en(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  function automatic logic parity_inv(input logic [1:0] mode);
    return (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy counter and registered status
// flags; a write while full is only accepted when a pop happens the same cycle.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic                     rd_en_i,
  input  logic [DATA_W-1:0]        din_i,
  output logic [DATA_W-1:0]        head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q, level_d;
  logic              full_q, empty_q, af_q;
  logic              push;

  assign push       = wr_en_i && !rst_i && (!full_q || rd_en_i);
  assign overflow_o = wr_en_i && !rst_i && full_q && !rd_en_i;
  assign head_o     = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    if (push && !rd_en_i)
      level_d = level_q + 1'b1;
    else if (!push && rd_en_i)
      level_d = level_q - 1'b1;
  end

  // Flags are derived from the next level so they are registered yet current.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == (AW+1)'(DEPTH));
      empty_q <= (level_d == '0);
      af_q    <= (level_d >= (AW+1)'(AF_LVL));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push)
      mem_q[wr_ptr_q] <= din_i;
  end

  assign full_o        = full_q;
  assign empty_o       = empty_q;
  assign almost_full_o = af_q;
  assign level_o       = level_q;

endmodule

// File: rtl/uart_tx_stream.sv
// FIFO-fed UART transmitter: pops one entry per frame and serialises it with
// start, LSB-first data, optional parity and one or two stop bits.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int AF_LVL     = FIFO_DEPTH - 2
) (
  input  logic                          clk_50m,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             din,
  input  logic                          wr_en,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int BW = $clog2(DATA_W);

  tx_state_e         state_q, state_d;
  logic              tx_q, tx_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
  logic [BW-1:0]     bits_q, bits_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_en_q, par_en_d, par_q, par_d;
  logic              two_stop_q, two_stop_d, stop2_q, stop2_d;
  logic              pop, bit_end;
  logic [DATA_W-1:0] head;

  assign pop = (state_q == IDLE) && !empty && !reset;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .AF_LVL (AF_LVL)
  ) u_fifo (
    .clk_i         (clk_50m),
    .rst_i         (reset),
    .wr_en_i       (wr_en),
    .rd_en_i       (pop),
    .din_i         (din),
    .head_o        (head),
    .full_o        (full),
    .empty_o       (empty),
    .almost_full_o (almost_full),
    .overflow_o    (overflow),
    .level_o       (level)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    bits_d     = bits_q;
    shreg_d    = shreg_q;
    par_en_d   = par_en_q;
    par_d      = par_q;
    two_stop_d = two_stop_q;
    stop2_d    = stop2_q;
    tx_done    = 1'b0;
    bit_end    = (cnt_q == DIV_W'(1));
    if (state_q != IDLE)
      cnt_d = bit_end ? div_q : cnt_q - 1'b1;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // Snapshot all runtime config so mid-frame changes only affect the next frame.
        if (pop) begin
          state_d    = START;
          tx_d       = 1'b0;
          div_d      = (baud_div == '0) ? DIV_W'(1) : baud_div;
          cnt_d      = div_d;
          shreg_d    = head;
          par_en_d   = parity_en(parity_mode);
          par_d      = (^head) ^ parity_inv(parity_mode);
          two_stop_d = two_stop;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          bits_d  = BW'(DATA_W - 1);
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bits_q == '0) begin
            stop2_d = 1'b0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bits_d  = bits_q - 1'b1;
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (two_stop_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            state_d = IDLE;
            tx_done = !reset;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      cnt_q   <= '0;
      bits_q  <= '0;
      stop2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      stop2_q <= stop2_d;
    end
  end

  always_ff @(posedge clk_50m) begin
    div_q      <= div_d;
    shreg_q    <= shreg_d;
    par_en_q   <= par_en_d;
    par_q      <= par_d;
    two_stop_q <= two_stop_d;
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: queue-based reference model checked every cycle,
// a table of single-frame vectors, and directed multi-cycle sequences.
module tb_uart_tx_stream;

  logic        clk_50m = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic        two_stop = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [15:0] baud_div = 16'd4;
  logic [1:0]  parity_mode = 2'b00;
  logic        tx, busy, tx_done, full, empty, almost_full, overflow;
  logic [4:0]  level;

  uart_tx_stream dut (
    .clk_50m     (clk_50m),
    .reset       (reset),
    .din         (din),
    .wr_en       (wr_en),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .tx          (tx),
    .busy        (busy),
    .tx_done     (tx_done),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow)
  );

  always #5 clk_50m = ~clk_50m;

  int nchk = 0;
  int nerr = 0;

  logic [7:0] fq[$];
  bit         wave[$];

  logic s_tx, s_busy, s_done, s_full, s_empty, s_af, s_ovf;
  int   s_level;

  int  flen[8];
  int  fgap[8];
  int  fdone_at[8];
  bit  fempty_start[8];
  int  fdone;
  bit  ftrace[$];

  int          hook_cyc = -1;
  logic [7:0]  hook_d = 8'h00;
  logic [15:0] hook_div = 16'd0;

  typedef struct {
    logic [7:0]  d;
    logic [1:0]  pm;
    logic        ts;
    logic [15:0] div;
    int          exp_len;
    int          exp_par;
  } vec_t;

  function automatic void chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void build_wave(input logic [7:0] d, input logic [15:0] div,
                                     input logic [1:0] pm, input logic ts);
    int dd;
    bit bits[$];
    dd = (div == 16'd0) ? 1 : int'(div);
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(d[k]);
    if (pm == 2'b01 || pm == 2'b10) bits.push_back((^d) ^ (pm == 2'b10));
    bits.push_back(1'b1);
    if (ts) bits.push_back(1'b1);
    foreach (bits[i])
      for (int r = 0; r < dd; r++) wave.push_back(bits[i]);
  endfunction

  // Called at posedge+1; drives inputs, checks at negedge, advances the model.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    bit idle, pop, acc;
    logic [7:0] e;
    wr_en = w;
    din   = d;
    reset = r;
    @(negedge clk_50m);
    s_tx = tx; s_busy = busy; s_done = tx_done; s_full = full;
    s_empty = empty; s_af = almost_full; s_ovf = overflow; s_level = int'(level);
    if (!r) begin
      idle = (wave.size() == 0);
      pop  = idle && (fq.size() > 0);
      chk("tx", s_tx, idle ? 1 : int'(wave[0]));
      chk("busy", s_busy, !idle);
      chk("tx_done", s_done, !idle && wave.size() == 1);
      chk("level", s_level, fq.size());
      chk("empty", s_empty, fq.size() == 0);
      chk("full", s_full, fq.size() == 16);
      chk("almost_full", s_af, fq.size() >= 14);
      chk("overflow", s_ovf, w && fq.size() == 16 && !pop);
      acc = w && (fq.size() < 16 || pop);
      if (!idle) void'(wave.pop_front());
      if (pop) begin
        e = fq.pop_front();
        build_wave(e, baud_div, parity_mode, two_stop);
      end
      if (acc) fq.push_back(d);
    end else begin
      fq.delete();
      wave.delete();
    end
    @(posedge clk_50m);
    #1;
  endtask

  task automatic run_frames(input int n);
    int k, run, gap, cyc;
    bit inf;
    k = 0; run = 0; gap = 0; cyc = 0; inf = 1'b0;
    fdone = 0;
    ftrace.delete();
    for (int i = 0; i < 8; i++) begin
      flen[i] = 0; fgap[i] = 0; fdone_at[i] = -1; fempty_start[i] = 1'b0;
    end
    while (k < n && cyc < 5000) begin
      if (cyc == hook_cyc) begin
        baud_div = hook_div;
        cycle(1'b1, hook_d, 1'b0);
      end else begin
        cycle(1'b0, 8'h00, 1'b0);
      end
      cyc++;
      if (s_busy) begin
        if (!inf) begin
          inf = 1'b1;
          run = 0;
          fgap[k] = gap;
          fempty_start[k] = s_empty;
        end
        run++;
        if (k == 0) ftrace.push_back(s_tx);
        if (s_done) begin
          fdone++;
          fdone_at[k] = run - 1;
        end
      end else if (inf) begin
        inf = 1'b0;
        flen[k] = run;
        k++;
        gap = 1;
      end else begin
        gap++;
      end
    end
    if (k < n) chk("frames_timeout", k, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int found, bcnt;

    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'hAA, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("rst_tx", s_tx, 1);
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_full", s_full, 0);
    chk("rst_af", s_af, 0);
    chk("rst_level", s_level, 0);

    // Single-frame vectors: data, parity_mode, two_stop, baud_div, length, parity bit
    vt[0] = '{8'h55, 2'b00, 1'b0, 16'd4, 40, -1};
    vt[1] = '{8'h07, 2'b01, 1'b0, 16'd4, 44,  1};
    vt[2] = '{8'h07, 2'b10, 1'b1, 16'd4, 48,  0};
    vt[3] = '{8'h3C, 2'b11, 1'b0, 16'd0, 10, -1};
    vt[4] = '{8'hFF, 2'b10, 1'b1, 16'd3, 36,  1};
    vt[5] = '{8'hA5, 2'b01, 1'b0, 16'd1, 11,  0};
    for (int i = 0; i < 6; i++) begin
      int dd, s, ones;
      logic [7:0] dec;
      baud_div    = vt[i].div;
      parity_mode = vt[i].pm;
      two_stop    = vt[i].ts;
      cycle(1'b1, vt[i].d, 1'b0);
      run_frames(1);
      dd = (vt[i].div == 16'd0) ? 1 : int'(vt[i].div);
      s  = vt[i].ts ? 2 : 1;
      chk($sformatf("vec%0d_len", i), flen[0], vt[i].exp_len);
      chk($sformatf("vec%0d_done_cnt", i), fdone, 1);
      chk($sformatf("vec%0d_done_at", i), fdone_at[0], vt[i].exp_len - 1);
      if (ftrace.size() == vt[i].exp_len) begin
        chk($sformatf("vec%0d_start", i), ftrace[0], 0);
        for (int k = 0; k < 8; k++) dec[k] = ftrace[(1 + k) * dd + dd / 2];
        chk($sformatf("vec%0d_data", i), dec, vt[i].d);
        if (vt[i].exp_par >= 0)
          chk($sformatf("vec%0d_parity", i), ftrace[9 * dd + dd / 2], vt[i].exp_par);
        ones = 0;
        for (int j = vt[i].exp_len - s * dd; j < vt[i].exp_len; j++) ones += ftrace[j];
        chk($sformatf("vec%0d_stop", i), ones, s * dd);
      end
    end

    // Back-to-back frames with a single idle cycle between them
    baud_div = 16'd2; parity_mode = 2'b00; two_stop = 1'b0;
    cycle(1'b1, 8'hA0, 1'b0);
    cycle(1'b1, 8'h0F, 1'b0);
    run_frames(2);
    chk("b2b_len0", flen[0], 20);
    chk("b2b_len1", flen[1], 20);
    chk("b2b_gap", fgap[1], 1);
    chk("b2b_empty0", fempty_start[0], 0);
    chk("b2b_empty1", fempty_start[1], 1);

    // baud_div raised mid-frame: only the next frame sees it
    baud_div = 16'd4;
    cycle(1'b1, 8'h5A, 1'b0);
    hook_cyc = 10; hook_d = 8'hC3; hook_div = 16'd8;
    run_frames(2);
    hook_cyc = -1;
    chk("baudchg_len0", flen[0], 40);
    chk("baudchg_len1", flen[1], 80);

    // Overflow: one frame in flight, then 17 writes into the idle FIFO
    cycle(1'b0, 8'h00, 1'b1);
    baud_div = 16'd100;
    cycle(1'b1, 8'h10, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      chk($sformatf("ovf_write%0d", i), s_ovf, i == 17);
      if (i == 17) begin
        chk("ovf_full", s_full, 1);
        chk("ovf_level", s_level, 16);
      end
    end
    found = 0;
    for (int c = 0; c < 1200 && found == 0; c++) begin
      cycle(1'b1, 8'hEE, 1'b0);
      if (!s_busy) found = 1;
    end
    chk("popwr_seen", found, 1);
    chk("popwr_ovf", s_ovf, 0);
    chk("popwr_level", s_level, 16);
    cycle(1'b0, 8'h00, 1'b0);
    chk("popwr_level_after", s_level, 16);
    chk("popwr_full_after", s_full, 1);
    cycle(1'b1, 8'h33, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("rstwr_level", s_level, 0);
    chk("rstwr_empty", s_empty, 1);
    chk("rstwr_busy", s_busy, 0);

    // Reset in the middle of the data bits of a 3-entry burst
    baud_div = 16'd4;
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h02, 1'b0);
    cycle(1'b1, 8'h03, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("midrst_tx", s_tx, 1);
    chk("midrst_busy", s_busy, 0);
    chk("midrst_level", s_level, 0);
    bcnt = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      bcnt += s_busy;
    end
    chk("midrst_no_frames", bcnt, 0);

    // Randomised traffic with per-cycle config churn and rare resets
    for (int c = 0; c < 400; c++) begin
      baud_div    = 16'($urandom_range(0, 3));
      parity_mode = 2'($urandom_range(0, 3));
      two_stop    = 1'($urandom_range(0, 1));
      cycle(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 299) == 0));
    end
    for (int c = 0; c < 3000 && (fq.size() > 0 || wave.size() > 0); c++)
      cycle(1'b0, 8'h00, 1'b0);
    chk("drain", fq.size() + wave.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/uart_tx_stream.md
UART_TX_STREAM -- requirements
Module: uart_tx_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per frame, legal 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning FIFO entries, power of two, at least 2.
REQ-003 SHALL have parameter DIV_W, default 16, meaning width of the runtime baud divisor.
REQ-004 SHALL have parameter AF_LVL, default FIFO_DEPTH-2, meaning the almost_full threshold.
REQ-005 SHALL have port clk_50m, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port din, input, DATA_W bits: write data.
REQ-008 SHALL have port wr_en, input, 1 bit: write strobe.
REQ-009 SHALL have port baud_div, input, DIV_W bits: clocks per bit; 0 is treated as 1.
REQ-010 SHALL have port parity_mode, input, 2 bits: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-011 SHALL have port two_stop, input, 1 bit: 1 selects 2 stop bits.
REQ-012 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-013 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-014 SHALL have port tx_done, output, 1 bit: one-cycle pulse in the last cycle of the final stop bit.
REQ-015 SHALL have ports full, empty and almost_full, outputs, 1 bit each: FIFO status, all registered.
REQ-016 SHALL have port level, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-017 SHALL have port overflow, output, 1 bit: one-cycle pulse when a write is dropped.

Function
REQ-018 SHALL accept a write when wr_en=1 and (full=0 or a pop occurs in the same cycle); otherwise drop it and pulse overflow.
REQ-019 SHALL update level on a write, on a pop, or hold it on both together; pointers wrap modulo FIFO_DEPTH.
REQ-020 SHALL assert almost_full when level >= AF_LVL, full when level == FIFO_DEPTH, and empty when level == 0.
REQ-021 SHALL NOT read data written in the same cycle; empty deasserts the cycle after the first write.
REQ-022 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP.
REQ-023 In IDLE with empty=0: pop the head entry, latch data, baud_div, parity_mode and two_stop into frame registers, and go to START.
REQ-024 Runtime config changes mid-frame SHALL NOT affect the frame in progress.
REQ-025 Each bit SHALL last exactly max(baud_div,1) cycles, timed by a down-counter reloaded at every bit boundary.
REQ-026 START drives tx=0; DATA drives DATA_W bits LSB first; PARITY (skipped when mode is none) drives the XOR of the data bits, inverted for odd; STOP drives 1 for one or two bit periods, then returns to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 tx SHALL be a registered output; the first START cycle occurs the cycle after the pop.
REQ-029 Back-to-back frames SHALL have exactly one IDLE cycle (tx=1) between the end of stop and the next start.
REQ-030 Frame length SHALL be D*(1+DATA_W+P+S) cycles, where D=max(baud_div,1), P is 1 if parity is enabled, and S is the number of stop bits.

Reset
REQ-031 On reset: tx=1, busy=0, tx_done=0, overflow=0, empty=1, full=0, almost_full=0, level=0, state=IDLE, pointers=0.
REQ-032 Reset mid-frame SHALL abort the frame (tx=1 the next cycle) and discard all FIFO contents.
REQ-033 Reset SHALL take priority over wr_en in the same cycle.

Structure
REQ-034 SHALL place the FSM state enum and the parity_mode encodings in the shared package uart_pkg.
REQ-035 SHALL use one sub-module, sync_fifo (show-ahead head output, level counter); all framing logic stays in uart_tx_stream.

Verification
REQ-036 Frame: baud_div=4, DATA_W=8, no parity, 1 stop, write 0x55 -> tx=0,1,0,1,0,1,0,1,0,1, 4 cycles each; 40-cycle frame; tx_done pulses once at cycle 40.
REQ-037 Even parity: write 0x07 with parity_mode=01 -> parity bit 1; with parity_mode=10 -> parity bit 0; two_stop=1 -> stop high for 8 cycles at baud_div=4.
REQ-038 Overflow: baud_div=100, 17 consecutive writes -> full=1 after write 16 and before the first pop, level=16, overflow pulses on write 17 only; write plus pop while full -> accepted, level unchanged.
REQ-039 Back-to-back: write 0xA0 and 0x0F -> exactly one tx=1 IDLE cycle between frames; empty=1 after the second pop.
REQ-040 Reset mid-DATA of a 3-entry burst -> tx=1 and busy=0 the next cycle, level=0, no further frames.
REQ-041 baud_div=0 -> each bit lasts 1 cycle; changing baud_div mid-frame from 4 to 8 -> current frame stays at 4, next frame at 8.
